// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch sequencer. Reads one 16-bit instruction word from program
// memory at the current program counter, holds it for the execution unit, and
// then advances the program counter. The counter either increments (wrapping
// modulo 1024) or loads the 10-bit jump target taken from the held
// instruction.
//
// Configuration macro:
//   FETCH_HALT_EN  - when defined, fetching the word 16'hFFFF stops the unit
//                    in a halt state that only reset leaves. When undefined,
//                    16'hFFFF is an ordinary instruction and halted is tied 0.
//
// Ports:
//   reloj        in   1   clock, all state changes on the rising edge
//   reset        in   1   synchronous active-high reset
//   mem_req      out  1   program-memory read request
//   mem_addr     out  10  read address (always equal to pc)
//   mem_ack      in   1   memory returns data this cycle (used only in S_REQ)
//   mem_rdata    in   16  instruction word, valid with mem_ack
//   instr        out  16  instruction register: opcode [15:10], target [9:0]
//   opcode       out  6   instr[15:10]
//   instr_valid  out  1   instr is held for execution
//   exec_done    in   1   consumer accepts instr (used only in S_ISSUE)
//   s_inc        in   1   1: next pc = pc+1, 0: next pc = instr[9:0]
//   pc           out  10  current program counter
//   halted       out  1   fetch stopped (constant 0 without FETCH_HALT_EN)
// ---------------------------------------------------------------------------
module fetch_unit (
    input  logic        reloj,
    input  logic        reset,
    output logic        mem_req,
    output logic [9:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        s_inc,
    output logic [9:0]  pc,
    output logic        halted
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  state_r;
    logic [1:0]  state_next_s;
    logic [9:0]  pc_r;
    logic [9:0]  pc_next_s;
    logic [15:0] instr_r;
    logic [15:0] instr_next_s;
    logic        mem_req_r;
    logic        instr_valid_r;

    // Next-state, next-pc and next-instruction decode.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        instr_next_s = instr_r;
        case (state_r)
            S_IDLE: begin
                state_next_s = S_REQ;
            end
            S_REQ: begin
                if (mem_ack) begin
                    // instr only ever changes here (or on reset).
                    instr_next_s = mem_rdata;
`ifdef FETCH_HALT_EN
                    if (mem_rdata == 16'hFFFF) begin
                        state_next_s = S_HALT;
                    end else begin
                        state_next_s = S_ISSUE;
                    end
`else
                    state_next_s = S_ISSUE;
`endif
                end else begin
                    // Hold request and address stable until the memory answers.
                    state_next_s = S_REQ;
                end
            end
            S_ISSUE: begin
                if (exec_done) begin
                    // 10-bit add wraps 1023 -> 0 by construction.
                    if (s_inc) begin
                        pc_next_s = pc_r + 10'd1;
                    end else begin
                        pc_next_s = instr_r[9:0];
                    end
                    state_next_s = S_REQ;
                end else begin
                    state_next_s = S_ISSUE;
                end
            end
            S_HALT: begin
`ifdef FETCH_HALT_EN
                state_next_s = S_HALT;
`else
                // Unreachable in this build; recover to a clean fetch.
                state_next_s = S_IDLE;
`endif
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset wins over every input.
    always_ff @(posedge reloj) begin
        if (reset) begin
            state_r       <= S_IDLE;
            pc_r          <= 10'd0;
            instr_r       <= 16'h0000;
            mem_req_r     <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            instr_r       <= instr_next_s;
            // Outputs are decoded from the next state so they are registered
            // yet line up exactly with the state they describe.
            mem_req_r     <= (state_next_s == S_REQ);
            instr_valid_r <= (state_next_s == S_ISSUE);
        end
    end

`ifdef FETCH_HALT_EN
    logic halted_r;

    // Halt flag register, set on entry to the halt state.
    always_ff @(posedge reloj) begin
        if (reset) begin
            halted_r <= 1'b0;
        end else begin
            halted_r <= (state_next_s == S_HALT);
        end
    end

    assign halted = halted_r;
`else
    assign halted = 1'b0;
`endif

    assign mem_req     = mem_req_r;
    assign mem_addr    = pc_r;
    assign pc          = pc_r;
    assign instr       = instr_r;
    assign opcode      = instr_r[15:10];
    assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. Directed scenarios (sequential fetch,
// delayed ack, consumer stall, jump, wrap, reset mid-request, the 16'hFFFF
// word) are followed by randomized stimulus. A transaction-level model of the
// fetch loop predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        reloj;
    logic        reset;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        exec_done;
    logic        s_inc;
    logic [9:0]  pc;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    // Reference model: what the fetch loop is doing right now.
    typedef enum int {M_IDLE, M_WAIT_MEM, M_HOLD, M_STOPPED} mphase_t;
    mphase_t     m_phase;
    int          m_pc;
    logic [15:0] m_instr;

    fetch_unit dut (
        .reloj      (reloj),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .opcode     (opcode),
        .instr_valid(instr_valid),
        .exec_done  (exec_done),
        .s_inc      (s_inc),
        .pc         (pc),
        .halted     (halted)
    );

    initial begin
        reloj = 1'b0;
        forever #5 reloj = ~reloj;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input bit r, input bit ack, input logic [15:0] d,
                              input bit done, input bit inc);
        if (r) begin
            m_phase = M_IDLE;
            m_pc    = 0;
            m_instr = 16'h0000;
        end else begin
            case (m_phase)
                M_IDLE: m_phase = M_WAIT_MEM;
                M_WAIT_MEM: begin
                    if (ack) begin
                        m_instr = d;
                        m_phase = (HALT_EN && d == 16'hFFFF) ? M_STOPPED : M_HOLD;
                    end
                end
                M_HOLD: begin
                    if (done) begin
                        m_pc    = inc ? (m_pc + 1) % 1024 : int'(m_instr & 16'h03FF);
                        m_phase = M_WAIT_MEM;
                    end
                end
                default: m_phase = M_STOPPED;
            endcase
        end
    endtask

    task automatic compare_all();
        check_eq("mem_req",     32'(mem_req),     32'(m_phase == M_WAIT_MEM));
        check_eq("mem_addr",    32'(mem_addr),    32'(m_pc));
        check_eq("pc",          32'(pc),          32'(m_pc));
        check_eq("instr",       32'(instr),       32'(m_instr));
        check_eq("opcode",      32'(opcode),      32'(m_instr >> 10));
        check_eq("instr_valid", 32'(instr_valid), 32'(m_phase == M_HOLD));
        check_eq("halted",      32'(halted),      32'(m_phase == M_STOPPED));
    endtask

    // Drive inputs (called just after a falling edge), take one rising edge,
    // then compare everything on the following falling edge.
    task automatic cycle(input bit r, input bit ack, input logic [15:0] d,
                         input bit done, input bit inc);
        reset     = r;
        mem_ack   = ack;
        mem_rdata = d;
        exec_done = done;
        s_inc     = inc;
        @(posedge reloj);
        model_step(r, ack, d, done, inc);
        @(negedge reloj);
        compare_all();
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom_range(0, 32'hFFFE));
        return w;
    endfunction

    initial begin
        logic [9:0]  held_addr;
        logic [15:0] held_instr;
        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        exec_done = 1'b0;
        s_inc     = 1'b0;
        m_phase   = M_IDLE;
        m_pc      = 0;
        m_instr   = 16'h0000;
        @(negedge reloj);

        // Reset state.
        cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
        check_eq("rst_pc",    32'(pc),          32'd0);
        check_eq("rst_instr", 32'(instr),       32'h0);
        check_eq("rst_req",   32'(mem_req),     32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_halt",  32'(halted),      32'd0);

        // Sequential fetch 0,1,2 with single-cycle memory.
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check_eq("seq_addr", 32'(mem_addr), 32'(k));
            check_eq("seq_req",  32'(mem_req),  32'd1);
            cycle(1'b0, 1'b1, rand_word(), 1'b0, 1'b0);
            check_eq("seq_valid", 32'(instr_valid), 32'd1);
            cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
            check_eq("seq_gap", 32'(instr_valid), 32'd0);
        end

        // Ack delayed by 3 cycles: request and address stay put.
        held_addr = mem_addr;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, rand_word(), 1'b1, 1'b0);
            check_eq("dly_req",   32'(mem_req),     32'd1);
            check_eq("dly_addr",  32'(mem_addr),    32'(held_addr));
            check_eq("dly_valid", 32'(instr_valid), 32'd0);
        end
        cycle(1'b0, 1'b1, 16'h0C05, 1'b0, 1'b0);
        check_eq("dly_lat", 32'(instr_valid), 32'd1);

        // Consumer stall for 5 cycles; stray acks must do nothing.
        held_instr = instr;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, rand_word(), 1'b0, 1'($urandom_range(0, 1)));
            check_eq("stall_instr", 32'(instr),   32'(held_instr));
            check_eq("stall_pc",    32'(pc),      32'(held_addr));
            check_eq("stall_req",   32'(mem_req), 32'd0);
        end
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Jump to 42.
        cycle(1'b0, 1'b1, 16'b111100_0000101010, 1'b0, 1'b0);
        check_eq("jmp_opcode", 32'(opcode), 32'h3C);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_eq("jmp_addr", 32'(mem_addr), 32'd42);

        // Jump to 1023, then increment wraps to 0.
        cycle(1'b0, 1'b1, 16'h07FF, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_eq("wrap_pre", 32'(mem_addr), 32'd1023);
        cycle(1'b0, 1'b1, rand_word(), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        check_eq("wrap_addr", 32'(mem_addr), 32'd0);

        // Reset lands on a request that is being acked.
        cycle(1'b0, 1'b1, 16'h1111, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        check_eq("rr_inreq", 32'(mem_req), 32'd1);
        cycle(1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0);
        check_eq("rr_instr", 32'(instr), 32'h0);
        check_eq("rr_pc",    32'(pc),    32'd0);

        // The 16'hFFFF word.
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_eq("ff_first", 32'(mem_addr), 32'd0);
        cycle(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (HALT_EN) begin
                check_eq("ff_halted", 32'(halted),  32'd1);
                check_eq("ff_noreq",  32'(mem_req), 32'd0);
                cycle(1'b0, 1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                check_eq("ff_valid", 32'(instr_valid), 32'd1);
                cycle(1'b0, 1'b1, rand_word(), 1'b0, 1'b0);
            end
        end
        cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                  16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
